data_mem_resp: RTL and testbench

Responder (slave) end of the core's data-memory request interface. It accepts one load or store at a time from a pipelined core's LSU over a valid/ready request channel, and returns a response after a fixed, configurable latency. Backing storage is an internal word-addressed RAM. The block replaces the zero-latency DPI memory model used in simulation with synthesizable, latency-bearing memory for multi-cycle cores.

---
 rtl/data_mem_resp_if.sv | 25 ++
 rtl/data_mem_resp.sv | 136 +++++++++++++
 tb/tb_data_mem_resp.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_resp_if.sv
// rtl/data_mem_resp_if.sv - data-memory request/response channel between LSU and memory responder
interface data_mem_resp_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_wen;
    logic [XLEN-1:0] req_addr;
    logic [3:0]      req_wstrb;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wstrb, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wstrb, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - single-outstanding data-memory responder with fixed response latency
module data_mem_resp #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] BASE_ADDR  = 32'h80000000,
    parameter int              DEPTH_LOG2 = 10,
    parameter int              LATENCY    = 2
) (
    input  logic          clk,
    input  logic          rst_b,
    data_mem_resp_if.slave bus
);
    localparam logic [XLEN-1:0] SPAN     = XLEN'(1) << (DEPTH_LOG2 + 2);
    localparam logic [3:0]      CNT_INIT = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  commit;

    logic [XLEN-1:0]       mem [0:(1 << DEPTH_LOG2) - 1];

    // latched request, used when the commit happens after a WAIT phase
    logic                  wen_q;
    logic                  in_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [3:0]            strb_q;
    logic [XLEN-1:0]       wdata_q;

    logic [XLEN-1:0]       offset;
    logic                  req_in;
    logic                  acc_wen;
    logic                  acc_in;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [3:0]            acc_strb;
    logic [XLEN-1:0]       acc_wdata;

    // addresses below BASE_ADDR wrap to huge offsets and fall out of range
    assign offset = bus.req_addr - BASE_ADDR;
    assign req_in = offset < SPAN;

    // with LATENCY=1 the commit edge is the accept edge, so use the live request
    assign acc_wen   = (state_q == IDLE) ? bus.req_wen   : wen_q;
    assign acc_in    = (state_q == IDLE) ? req_in        : in_q;
    assign acc_idx   = (state_q == IDLE) ? offset[DEPTH_LOG2+1:2] : idx_q;
    assign acc_strb  = (state_q == IDLE) ? bus.req_wstrb : strb_q;
    assign acc_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;

    assign bus.rsp_valid = (state_q == RESP);

    // state and latency counter registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // next-state, request ready and commit strobe
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        commit        = 1'b0;
        bus.req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // capture the accepted request
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wen_q   <= 1'b0;
            in_q    <= 1'b0;
            idx_q   <= '0;
            strb_q  <= 4'd0;
            wdata_q <= '0;
        end else if (state_q == IDLE && bus.req_valid) begin
            wen_q   <= bus.req_wen;
            in_q    <= req_in;
            idx_q   <= offset[DEPTH_LOG2+1:2];
            strb_q  <= bus.req_wstrb;
            wdata_q <= bus.req_wdata;
        end
    end

    // response registers, loaded only on the commit edge and held through RESP
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else if (commit) begin
            bus.rsp_rdata <= (!acc_wen && acc_in) ? mem[acc_idx] : '0;
            bus.rsp_err   <= !acc_in;
        end
    end

    // byte-lane RAM write; contents survive reset
    always_ff @(posedge clk) begin
        if (commit && rst_b && acc_wen && acc_in) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_strb[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_mem_resp.sv
// tb/tb_data_mem_resp.sv - randomized self-checking bench for data_mem_resp
module tb_data_mem_resp;
    localparam int LAT = 2;
    localparam longint BASE = 64'h80000000;
    localparam longint SPAN = 4096;

    logic clk;
    logic rst_b;
    int   checks;
    int   errors;

    logic [31:0] model [int];

    data_mem_resp_if #(.XLEN(32)) bus  ();
    data_mem_resp_if #(.XLEN(32)) bus1 ();

    data_mem_resp #(.XLEN(32), .BASE_ADDR(32'h80000000), .DEPTH_LOG2(10), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    data_mem_resp #(.XLEN(32), .BASE_ADDR(32'h80000000), .DEPTH_LOG2(10), .LATENCY(1)) dut1 (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // one full transaction on the LATENCY=LAT responder, hold = cycles of rsp_ready low
    task automatic do_txn(input logic wen, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] wdata, input int hold,
                          output logic [31:0] rdata, output logic err);
        int n;
        @(negedge clk);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_wen   = wen;
        bus.req_addr  = addr;
        bus.req_wstrb = strb;
        bus.req_wdata = wdata;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_wen   = 1'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wstrb = 4'($urandom);
        bus.req_wdata = $urandom;
        n = 1;
        while (!bus.rsp_valid && n < 40) begin
            chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 32'(n), 32'(LAT));
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        for (int h = 0; h <= hold; h++) begin
            bus.rsp_ready = (h == hold);
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_ready", 32'(bus.req_ready), 32'd0);
            chk("hold_rdata", bus.rsp_rdata, rdata);
            chk("hold_err", 32'(bus.rsp_err), 32'(err));
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 1'b0;
        chk("post_valid", 32'(bus.rsp_valid), 32'd0);
        chk("post_ready", 32'(bus.req_ready), 32'd1);
        chk("post_rdata", bus.rsp_rdata, rdata);
        chk("post_err", 32'(bus.rsp_err), 32'(err));
    endtask

    // transaction checked against the array model
    task automatic model_txn(input logic wen, input logic [31:0] addr, input logic [3:0] strb,
                             input logic [31:0] wdata, input int hold, output logic [31:0] rdata);
        longint a;
        bit     in_range;
        int     key;
        logic [31:0] exp_rd;
        logic [31:0] w;
        logic        err;
        a        = longint'(addr);
        in_range = (a >= BASE) && (a < BASE + SPAN);
        key      = in_range ? int'((a - BASE) / 4) : 0;
        exp_rd   = 32'd0;
        if (!wen && in_range) exp_rd = model.exists(key) ? model[key] : 32'hxxxxxxxx;
        do_txn(wen, addr, strb, wdata, hold, rdata, err);
        chk("rsp_err", 32'(err), 32'(!in_range));
        if (exp_rd !== 32'hxxxxxxxx) chk("rsp_rdata", rdata, exp_rd);
        if (wen && in_range) begin
            w = model.exists(key) ? model[key] : 32'd0;
            for (int i = 0; i < 4; i++) if (strb[i]) w[8*i +: 8] = wdata[8*i +: 8];
            model[key] = w;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] addr;
        int          idx;
        int          r;
        checks = 0;
        errors = 0;
        rst_b  = 1'b0;
        bus.req_valid = 0; bus.req_wen = 0; bus.req_addr = 0; bus.req_wstrb = 0;
        bus.req_wdata = 0; bus.rsp_ready = 0;
        bus1.req_valid = 0; bus1.req_wen = 0; bus1.req_addr = 0; bus1.req_wstrb = 0;
        bus1.req_wdata = 0; bus1.rsp_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst_b = 1'b1;

        // seed a working set of words
        for (int i = 0; i < 17; i++) begin
            idx = (i == 16) ? 1023 : i;
            model_txn(1'b1, 32'(BASE + 4 * idx), 4'hF, $urandom, 0, rd);
        end

        // directed: full write, low-bit-ignored read, partial strobe
        model_txn(1'b1, 32'h80000010, 4'hF, 32'hDEADBEEF, 0, rd);
        chk("wr_rdata_zero", rd, 32'd0);
        model_txn(1'b0, 32'h80000013, 4'h0, 32'h0, 0, rd);
        chk("rd_deadbeef", rd, 32'hDEADBEEF);
        model_txn(1'b1, 32'h80000010, 4'b0101, 32'h11223344, 0, rd);
        model_txn(1'b0, 32'h80000010, 4'h0, 32'h0, 0, rd);
        chk("partial_strobe", rd, 32'hDE22BE44);
        model_txn(1'b1, 32'h80000010, 4'h0, 32'hCAFEF00D, 0, rd);
        model_txn(1'b0, 32'h80000010, 4'h0, 32'h0, 0, rd);
        chk("zero_strobe", rd, 32'hDE22BE44);

        // backpressure
        model_txn(1'b0, 32'h80000010, 4'h0, 32'h0, 5, rd);

        // range errors and boundaries
        model_txn(1'b0, 32'h7FFFFFFC, 4'h0, 32'h0, 0, rd);
        chk("below_base_rdata", rd, 32'd0);
        model_txn(1'b1, 32'h80001000, 4'hF, 32'h55555555, 1, rd);
        model_txn(1'b0, 32'h80000FFC, 4'h0, 32'h0, 0, rd);
        model_txn(1'b0, 32'h80000000, 4'h0, 32'h0, 0, rd);

        // reset during WAIT drops the pending write
        model_txn(1'b1, 32'h80000020, 4'hF, 32'h00000001, 0, rd);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b1;
        bus.req_addr  = 32'h80000020;
        bus.req_wstrb = 4'hF;
        bus.req_wdata = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("wait_valid", 32'(bus.rsp_valid), 32'd0);
        chk("wait_ready", 32'(bus.req_ready), 32'd0);
        rst_b = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_mid_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        model_txn(1'b0, 32'h80000020, 4'h0, 32'h0, 0, rd);
        chk("rst_drop_write", rd, 32'h00000001);

        // randomized traffic
        for (int t = 0; t < 80; t++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                addr = 32'(BASE - 4 * $urandom_range(1, 8)) | 32'($urandom_range(0, 3));
            end else if (r == 1) begin
                addr = 32'(BASE + SPAN + $urandom_range(0, 255));
            end else begin
                idx  = $urandom_range(0, 16);
                if (idx == 16) idx = 1023;
                addr = 32'(BASE + 4 * idx + $urandom_range(0, 3));
            end
            model_txn(1'($urandom), addr, 4'($urandom), $urandom, $urandom_range(0, 3), rd);
        end

        // LATENCY=1 responder: back-to-back issue every two edges
        @(negedge clk);
        bus1.rsp_ready = 1'b1;
        bus1.req_valid = 1'b1;
        bus1.req_wen   = 1'b1;
        bus1.req_addr  = 32'h80000004;
        bus1.req_wstrb = 4'hF;
        bus1.req_wdata = 32'hA5A55A5A;
        @(posedge clk);
        #1;
        bus1.req_valid = 1'b0;
        chk("l1_wr_valid", 32'(bus1.rsp_valid), 32'd1);
        chk("l1_wr_ready", 32'(bus1.req_ready), 32'd0);
        chk("l1_wr_rdata", bus1.rsp_rdata, 32'd0);
        chk("l1_wr_err", 32'(bus1.rsp_err), 32'd0);
        @(posedge clk);
        #1;
        chk("l1_idle_valid", 32'(bus1.rsp_valid), 32'd0);
        chk("l1_idle_ready", 32'(bus1.req_ready), 32'd1);
        bus1.req_valid = 1'b1;
        bus1.req_wen   = 1'b0;
        bus1.req_addr  = 32'h80000006;
        @(posedge clk);
        #1;
        bus1.req_valid = 1'b0;
        chk("l1_rd_valid", 32'(bus1.rsp_valid), 32'd1);
        chk("l1_rd_rdata", bus1.rsp_rdata, 32'hA5A55A5A);
        @(posedge clk);
        #1;
        bus1.req_valid = 1'b1;
        bus1.req_addr  = 32'h80001000;
        @(posedge clk);
        #1;
        bus1.req_valid = 1'b0;
        chk("l1_oor_err", 32'(bus1.rsp_err), 32'd1);
        chk("l1_oor_rdata", bus1.rsp_rdata, 32'd0);
        @(posedge clk);
        #1;
        chk("l1_end_valid", 32'(bus1.rsp_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
